// File: rtl/mini_src_pkg.sv
// Mini-SRC control unit shared definitions: opcodes, state codes,
// strobe bit positions and the opcode classifier used by the sequencer.
package mini_src_pkg;

  localparam int OP_WIDTH = 5;
  typedef logic [OP_WIDTH-1:0] opcode_t;

  // Instruction opcodes (IR[31:27])
  localparam opcode_t OP_LD   = 5'b00000;
  localparam opcode_t OP_LDI  = 5'b00001;
  localparam opcode_t OP_ST   = 5'b00010;
  localparam opcode_t OP_ADD  = 5'b00011;
  localparam opcode_t OP_SUB  = 5'b00100;
  localparam opcode_t OP_AND  = 5'b00101;
  localparam opcode_t OP_OR   = 5'b00110;
  localparam opcode_t OP_SHR  = 5'b00111;
  localparam opcode_t OP_SHL  = 5'b01000;
  localparam opcode_t OP_ROR  = 5'b01001;
  localparam opcode_t OP_ROL  = 5'b01010;
  localparam opcode_t OP_ADDI = 5'b01011;
  localparam opcode_t OP_ANDI = 5'b01100;
  localparam opcode_t OP_ORI  = 5'b01101;
  localparam opcode_t OP_MUL  = 5'b01110;
  localparam opcode_t OP_DIV  = 5'b01111;
  localparam opcode_t OP_NEG  = 5'b10000;
  localparam opcode_t OP_NOT  = 5'b10001;
  localparam opcode_t OP_NOP  = 5'b11010;
  localparam opcode_t OP_HALT = 5'b11011;

  // Address arithmetic (ldi/ld/st) always uses the adder
  localparam opcode_t ALU_ADD = OP_ADD;

  // Sequencer state codes (4-bit, legacy-compatible constants)
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_T0     = 4'd1;
  localparam logic [3:0] S_T1     = 4'd2;
  localparam logic [3:0] S_T2     = 4'd3;
  localparam logic [3:0] S_T3     = 4'd4;
  localparam logic [3:0] S_T4     = 4'd5;
  localparam logic [3:0] S_T5     = 4'd6;
  localparam logic [3:0] S_T6     = 4'd7;
  localparam logic [3:0] S_T7     = 4'd8;
  localparam logic [3:0] S_HALTED = 4'd9;

  // bus_out bit positions
  localparam int BUS_PCOUT    = 7;
  localparam int BUS_ZHIGHOUT = 6;
  localparam int BUS_ZLOWOUT  = 5;
  localparam int BUS_MDROUT   = 4;
  localparam int BUS_HIOUT    = 3;
  localparam int BUS_LOOUT    = 2;
  localparam int BUS_COUT     = 1;
  localparam int BUS_ROUT     = 0;

  // reg_in bit positions
  localparam int REG_PCIN  = 8;
  localparam int REG_MARIN = 7;
  localparam int REG_MDRIN = 6;
  localparam int REG_IRIN  = 5;
  localparam int REG_YIN   = 4;
  localparam int REG_ZIN   = 3;
  localparam int REG_HIIN  = 2;
  localparam int REG_LOIN  = 1;
  localparam int REG_RIN   = 0;

  // Execute-step families: opcodes in one class share a step sequence
  typedef enum logic [3:0] {
    CLS_R, CLS_IMM, CLS_LDI, CLS_LD, CLS_ST,
    CLS_MULDIV, CLS_NEGNOT, CLS_NOP, CLS_HALT, CLS_ILL
  } op_class_e;

  function automatic op_class_e op_class(input opcode_t op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: return CLS_R;
      OP_ADDI, OP_ANDI, OP_ORI:       return CLS_IMM;
      OP_LDI:                         return CLS_LDI;
      OP_LD:                          return CLS_LD;
      OP_ST:                          return CLS_ST;
      OP_MUL, OP_DIV:                 return CLS_MULDIV;
      OP_NEG, OP_NOT:                 return CLS_NEGNOT;
      OP_NOP:                         return CLS_NOP;
      OP_HALT:                        return CLS_HALT;
      default:                        return CLS_ILL;
    endcase
  endfunction

  // Final execute step of each class; classes without execute steps end at T2
  function automatic logic [3:0] last_step(input op_class_e c);
    case (c)
      CLS_R, CLS_IMM, CLS_LDI: return S_T5;
      CLS_LD, CLS_ST:          return S_T7;
      CLS_MULDIV:              return S_T6;
      CLS_NEGNOT:              return S_T4;
      default:                 return S_T2;
    endcase
  endfunction

endpackage

// File: rtl/mini_src_mem_wait.sv
// Memory-step wait counter: counts stalled cycles of the active memory
// step and flags a timeout on the MEM_WAIT_MAX-th consecutive stall.
module mini_src_mem_wait #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic Clock,
  input  logic Clear,
  input  logic step_active,
  input  logic MemReady,
  output logic done,
  output logic timeout
);

  localparam int CW = $clog2(MEM_WAIT_MAX + 1);

  logic [CW-1:0] wait_cnt;
  logic          stalled;

  assign stalled = step_active & ~MemReady;
  assign done    = step_active & MemReady;
  assign timeout = stalled & (wait_cnt == CW'(MEM_WAIT_MAX - 1));

  // Count stalled cycles; restart whenever the step completes, ends or times out
  always_ff @(posedge Clock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (Clear || !stalled || timeout) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mini_src_control_unit.sv
// Hardwired Mini-SRC control sequencer. Fetch T0-T2, opcode-driven execute
// T3-T7, Moore-decoded strobes. Optional macro MINI_SRC_ILLEGAL_TRAP_EN
// traps unlisted opcodes into HALTED and exposes a sticky Illegal port.
module mini_src_control_unit
  import mini_src_pkg::*;
#(
  parameter int OPW          = OP_WIDTH,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic        Start,
  input  logic        Stop,
  input  logic [31:0] IR,
  input  logic        MemReady,
  output logic [7:0]  bus_out,
  output logic [8:0]  reg_in,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        BAout,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  ALU_op,
  output logic        Running,
  output logic        Fault
`ifdef MINI_SRC_ILLEGAL_TRAP_EN
  ,
  output logic        Illegal
`endif
);

`ifdef MINI_SRC_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [3:0] state_q, state_d, end_state;
  opcode_t    ir_op, op_q;
  op_class_e  ir_cls, ex_cls;
  logic       stop_q, fault_q, illegal_q;
  logic       mem_step, mem_done, mem_timeout, can_start, trap_now;
  logic       unused_ir;

  // Register fields are decoded by the datapath's select-and-encode logic
  assign unused_ir = ^IR[31-OPW:0];

  assign ir_op  = IR[31 -: OPW];
  assign ir_cls = op_class(ir_op);
  assign ex_cls = op_class(op_q);

  assign mem_step = (state_q == S_T1)
                  | ((state_q == S_T6) & (ex_cls == CLS_LD))
                  | ((state_q == S_T7) & (ex_cls == CLS_ST));

  mini_src_mem_wait #(
    .MEM_WAIT_MAX (MEM_WAIT_MAX)
  ) u_mem_wait (
    .Clock       (Clock),
    .Clear       (Clear),
    .step_active (mem_step),
    .MemReady    (MemReady),
    .done        (mem_done),
    .timeout     (mem_timeout)
  );

  // A Stop pulse arriving in the final step still counts for this instruction
  assign end_state = (stop_q || Stop) ? S_HALTED : S_T0;
  assign can_start = Start & ~fault_q & ~illegal_q;
  assign trap_now  = TRAP_EN & (state_q == S_T2) & (ir_cls == CLS_ILL);
  assign Running   = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign Fault     = fault_q;
`ifdef MINI_SRC_ILLEGAL_TRAP_EN
  assign Illegal   = illegal_q;
`endif

  // Next-state: fetch, opcode dispatch in T2, execute with memory stalls
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALTED: if (can_start) state_d = S_T0;
      S_T2: begin
        case (ir_cls)
          CLS_HALT: state_d = S_HALTED;
          CLS_NOP:  state_d = end_state;
          CLS_ILL:  state_d = TRAP_EN ? S_HALTED : end_state;
          default:  state_d = S_T3;
        endcase
      end
      S_T0, S_T1, S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (mem_timeout) begin
          state_d = S_HALTED;
        end else if (!mem_step || mem_done) begin
          if (state_q >= S_T3 && state_q == last_step(ex_cls)) state_d = end_state;
          else                                                 state_d = state_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched opcode, Stop latch and sticky error flags
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      stop_q    <= 1'b0;
      fault_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_T2) op_q <= ir_op;
      if (state_d == S_HALTED && state_q != S_HALTED) stop_q <= 1'b0;
      else if (Stop && Running)                        stop_q <= 1'b1;
      if (mem_timeout) fault_q   <= 1'b1;
      if (trap_now)    illegal_q <= 1'b1;
    end
  end

  // Moore strobe decode from the registered state and latched opcode
  always_comb begin
    bus_out = '0;
    reg_in  = '0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Grc     = 1'b0;
    BAout   = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    Write   = 1'b0;
    ALU_op  = '0;
    case (state_q)
      S_T0: begin
        bus_out[BUS_PCOUT] = 1'b1;
        reg_in[REG_MARIN]  = 1'b1;
        reg_in[REG_ZIN]    = 1'b1;
        IncPC              = 1'b1;
      end
      S_T1: begin
        bus_out[BUS_ZLOWOUT] = 1'b1;
        reg_in[REG_PCIN]     = 1'b1;
        reg_in[REG_MDRIN]    = 1'b1;
        Read                 = 1'b1;
      end
      S_T2: begin
        bus_out[BUS_MDROUT] = 1'b1;
        reg_in[REG_IRIN]    = 1'b1;
      end
      S_T3: begin
        case (ex_cls)
          CLS_R, CLS_IMM: begin
            Grb = 1'b1; bus_out[BUS_ROUT] = 1'b1; reg_in[REG_YIN] = 1'b1;
          end
          CLS_LDI, CLS_LD, CLS_ST: begin
            Grb = 1'b1; BAout = 1'b1; reg_in[REG_YIN] = 1'b1;
          end
          CLS_MULDIV: begin
            Gra = 1'b1; bus_out[BUS_ROUT] = 1'b1; reg_in[REG_YIN] = 1'b1;
          end
          CLS_NEGNOT: begin
            Grb = 1'b1; bus_out[BUS_ROUT] = 1'b1; ALU_op = op_q; reg_in[REG_ZIN] = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        case (ex_cls)
          CLS_R: begin
            Grc = 1'b1; bus_out[BUS_ROUT] = 1'b1; ALU_op = op_q; reg_in[REG_ZIN] = 1'b1;
          end
          CLS_IMM: begin
            bus_out[BUS_COUT] = 1'b1; ALU_op = op_q; reg_in[REG_ZIN] = 1'b1;
          end
          CLS_LDI, CLS_LD, CLS_ST: begin
            bus_out[BUS_COUT] = 1'b1; ALU_op = ALU_ADD; reg_in[REG_ZIN] = 1'b1;
          end
          CLS_MULDIV: begin
            Grb = 1'b1; bus_out[BUS_ROUT] = 1'b1; ALU_op = op_q; reg_in[REG_ZIN] = 1'b1;
          end
          CLS_NEGNOT: begin
            bus_out[BUS_ZLOWOUT] = 1'b1; Gra = 1'b1; reg_in[REG_RIN] = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (ex_cls)
          CLS_R, CLS_IMM, CLS_LDI: begin
            bus_out[BUS_ZLOWOUT] = 1'b1; Gra = 1'b1; reg_in[REG_RIN] = 1'b1;
          end
          CLS_LD, CLS_ST: begin
            bus_out[BUS_ZLOWOUT] = 1'b1; reg_in[REG_MARIN] = 1'b1;
          end
          CLS_MULDIV: begin
            bus_out[BUS_ZLOWOUT] = 1'b1; reg_in[REG_LOIN] = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (ex_cls)
          CLS_LD: begin
            Read = 1'b1; reg_in[REG_MDRIN] = 1'b1;
          end
          CLS_ST: begin
            Gra = 1'b1; bus_out[BUS_ROUT] = 1'b1; reg_in[REG_MDRIN] = 1'b1;
          end
          CLS_MULDIV: begin
            bus_out[BUS_ZHIGHOUT] = 1'b1; reg_in[REG_HIIN] = 1'b1;
          end
          default: ;
        endcase
      end
      S_T7: begin
        case (ex_cls)
          CLS_LD: begin
            bus_out[BUS_MDROUT] = 1'b1; Gra = 1'b1; reg_in[REG_RIN] = 1'b1;
          end
          CLS_ST:  Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mini_src_control_unit.sv
// Self-checking bench for mini_src_control_unit. The reference model builds,
// per opcode, the list of strobe vectors an instruction must walk through and
// replays it cycle by cycle with randomized memory stalls.
// Honors MINI_SRC_ILLEGAL_TRAP_EN when defined.
module tb_mini_src_control_unit;

  logic        Clock = 1'b0;
  logic        Clear, Start, Stop, MemReady;
  logic [31:0] IR;
  logic [7:0]  bus_out;
  logic [8:0]  reg_in;
  logic        Gra, Grb, Grc, BAout, IncPC, Read, Write;
  logic [4:0]  ALU_op;
  logic        Running, Fault;
  logic        ill_obs;

  always #5 Clock = ~Clock;

  mini_src_control_unit #(.OPW(5), .MEM_WAIT_MAX(15)) dut (
    .Clock    (Clock),
    .Clear    (Clear),
    .Start    (Start),
    .Stop     (Stop),
    .IR       (IR),
    .MemReady (MemReady),
    .bus_out  (bus_out),
    .reg_in   (reg_in),
    .Gra      (Gra),
    .Grb      (Grb),
    .Grc      (Grc),
    .BAout    (BAout),
    .IncPC    (IncPC),
    .Read     (Read),
    .Write    (Write),
    .ALU_op   (ALU_op),
    .Running  (Running),
    .Fault    (Fault)
`ifdef MINI_SRC_ILLEGAL_TRAP_EN
    ,
    .Illegal  (ill_obs)
`endif
  );

`ifndef MINI_SRC_ILLEGAL_TRAP_EN
  assign ill_obs = 1'b0;
`endif

  // Bus drivers, load enables and flags {Gra,Grb,Grc,BAout,IncPC,Read,Write}
  localparam logic [7:0] B_PC = 8'h80, B_ZH = 8'h40, B_ZL = 8'h20, B_MDR = 8'h10;
  localparam logic [7:0] B_C  = 8'h02, B_R  = 8'h01;
  localparam logic [8:0] R_PC = 9'h100, R_MAR = 9'h080, R_MDR = 9'h040, R_IR = 9'h020;
  localparam logic [8:0] R_Y  = 9'h010, R_Z   = 9'h008, R_HI  = 9'h004, R_LO = 9'h002;
  localparam logic [8:0] R_R  = 9'h001;
  localparam logic [6:0] F_GRA = 7'b1000000, F_GRB = 7'b0100000, F_GRC = 7'b0010000;
  localparam logic [6:0] F_BA  = 7'b0001000, F_INC = 7'b0000100, F_RD  = 7'b0000010;
  localparam logic [6:0] F_WR  = 7'b0000001;

  typedef struct packed {
    logic        mem;
    logic [28:0] v;
  } step_t;

  step_t seq_q[$];
  int    checks   = 0;
  int    failures = 0;
  logic  m_fault   = 1'b0;
  logic  m_illegal = 1'b0;

  function automatic step_t mk(logic mem, logic [7:0] b, logic [8:0] r, logic [6:0] f, logic [4:0] a);
    return {mem, b, r, f, a};
  endfunction

  function automatic bit listed(logic [4:0] op);
    return (op <= 5'd17) || (op == 5'd26) || (op == 5'd27);
  endfunction

  // Expected strobe sequence of one instruction, straight from the ISA table
  function automatic void build_seq(logic [4:0] op);
    seq_q.delete();
    seq_q.push_back(mk(0, B_PC,  R_MAR | R_Z,  F_INC, 0));
    seq_q.push_back(mk(1, B_ZL,  R_PC | R_MDR, F_RD,  0));
    seq_q.push_back(mk(0, B_MDR, R_IR,         0,     0));
    if (op >= 5'd3 && op <= 5'd10) begin
      seq_q.push_back(mk(0, B_R,  R_Y, F_GRB, 0));
      seq_q.push_back(mk(0, B_R,  R_Z, F_GRC, op));
      seq_q.push_back(mk(0, B_ZL, R_R, F_GRA, 0));
    end else if (op >= 5'd11 && op <= 5'd13) begin
      seq_q.push_back(mk(0, B_R,  R_Y, F_GRB, 0));
      seq_q.push_back(mk(0, B_C,  R_Z, 0,     op));
      seq_q.push_back(mk(0, B_ZL, R_R, F_GRA, 0));
    end else if (op <= 5'd2) begin
      seq_q.push_back(mk(0, 0,   R_Y, F_GRB | F_BA, 0));
      seq_q.push_back(mk(0, B_C, R_Z, 0,            5'd3));
      if (op == 5'd1) begin
        seq_q.push_back(mk(0, B_ZL, R_R, F_GRA, 0));
      end else if (op == 5'd0) begin
        seq_q.push_back(mk(0, B_ZL,  R_MAR, 0,     0));
        seq_q.push_back(mk(1, 0,     R_MDR, F_RD,  0));
        seq_q.push_back(mk(0, B_MDR, R_R,   F_GRA, 0));
      end else begin
        seq_q.push_back(mk(0, B_ZL, R_MAR, 0,     0));
        seq_q.push_back(mk(0, B_R,  R_MDR, F_GRA, 0));
        seq_q.push_back(mk(1, 0,    0,     F_WR,  0));
      end
    end else if (op == 5'd14 || op == 5'd15) begin
      seq_q.push_back(mk(0, B_R,  R_Y,  F_GRA, 0));
      seq_q.push_back(mk(0, B_R,  R_Z,  F_GRB, op));
      seq_q.push_back(mk(0, B_ZL, R_LO, 0,     0));
      seq_q.push_back(mk(0, B_ZH, R_HI, 0,     0));
    end else if (op == 5'd16 || op == 5'd17) begin
      seq_q.push_back(mk(0, B_R,  R_Z, F_GRB, op));
      seq_q.push_back(mk(0, B_ZL, R_R, F_GRA, 0));
    end
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [28:0] exp_v, input logic exp_run);
    logic [31:0] obs, expv;
    obs  = {bus_out, reg_in, Gra, Grb, Grc, BAout, IncPC, Read, Write, ALU_op,
            Running, Fault, ill_obs};
    expv = {exp_v, exp_run, m_fault, m_illegal};
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Replays one instruction from T0; negative stall/stop/clear args mean random/none
  task automatic run_instr(input string name, input logic [31:0] ir, input int t1_stall,
                           input int ex_stall, input int stop_at, input int clear_at,
                           output bit halted);
    logic [4:0]  op;
    logic [28:0] t0_v;
    bit          stop_seen, ends_halt;
    int          n;
    step_t       s;
    op = ir[31:27];
    IR = ir;
    build_seq(op);
    t0_v      = seq_q[0].v;
    ends_halt = (op == 5'd27);
`ifdef MINI_SRC_ILLEGAL_TRAP_EN
    if (!listed(op)) ends_halt = 1'b1;
`endif
    stop_seen = 1'b0;
    halted    = 1'b0;
    foreach (seq_q[idx]) begin
      s = seq_q[idx];
      n = 0;
      if (s.mem) begin
        if (idx == 1) n = (t1_stall < 0) ? int'($urandom_range(0, 4)) : t1_stall;
        else          n = (ex_stall < 0) ? int'($urandom_range(0, 4)) : ex_stall;
      end
      for (int c = 0; c <= n; c++) begin
        MemReady = s.mem ? (c == n) : 1'($urandom_range(0, 1));
        check_outs($sformatf("%s_op%0d_s%0d_c%0d", name, op, idx, c), s.v, 1'b1);
        if (idx == clear_at) begin
          Clear = 1'b1;
          tick();
          Clear     = 1'b0;
          m_fault   = 1'b0;
          m_illegal = 1'b0;
          check_outs({name, "_cleared"}, '0, 1'b0);
          halted = 1'b1;
          return;
        end
        if (idx == stop_at && c == 0) begin
          Stop      = 1'b1;
          stop_seen = 1'b1;
        end
        tick();
        Stop = 1'b0;
      end
    end
`ifdef MINI_SRC_ILLEGAL_TRAP_EN
    if (!listed(op)) m_illegal = 1'b1;
`endif
    halted = ends_halt || stop_seen;
    check_outs({name, "_end"}, halted ? 29'd0 : t0_v, !halted);
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  initial begin
    bit          h;
    int          stop_at;
    logic [31:0] ir;
    logic [28:0] t0_v, t1_v;

    Clear = 1'b1; Start = 1'b0; Stop = 1'b0; MemReady = 1'b0; IR = '0;
    tick();
    tick();
    check_outs("reset", '0, 1'b0);
    Clear = 1'b0;
    tick();
    check_outs("idle_hold", '0, 1'b0);

    build_seq(5'd0);
    t0_v = seq_q[0].v;
    t1_v = seq_q[1].v;

    // and R1,R2,R3 with no stalls, then ld with a 3-cycle stall in T6
    pulse_start();
    run_instr("and", 32'h28918000, 0, 0, -1, -1, h);
    run_instr("ld_stall3", 32'h00880010, 0, 3, -1, -1, h);

    // mul aborted by Clear in T4: no HI/LO load ever appears
    run_instr("mul_clear", 32'h70880000, 0, 0, -1, 4, h);
    tick();
    check_outs("mul_clear_idle", '0, 1'b0);

    // halt, then restart
    pulse_start();
    run_instr("halt", 32'hD8000000, 0, 0, -1, -1, h);
    pulse_start();
    check_outs("restart_t0", t0_v, 1'b1);

    // Stop during T3 of add: instruction completes, then HALTED
    run_instr("add_stop", 32'h18918000, 0, 0, 3, -1, h);

    // Memory timeout in T1: 15 stalled cycles, then HALTED with Fault
    pulse_start();
    IR       = 32'h18000000;
    MemReady = 1'b0;
    check_outs("to_t0", t0_v, 1'b1);
    tick();
    for (int i = 0; i < 15; i++) begin
      check_outs($sformatf("to_t1_%0d", i), t1_v, 1'b1);
      tick();
    end
    m_fault = 1'b1;
    check_outs("to_halted", '0, 1'b0);
    pulse_start();
    tick();
    check_outs("to_start_ignored", '0, 1'b0);
    Clear = 1'b1;
    tick();
    Clear   = 1'b0;
    m_fault = 1'b0;
    check_outs("to_cleared", '0, 1'b0);

`ifdef MINI_SRC_ILLEGAL_TRAP_EN
    pulse_start();
    run_instr("illegal", 32'hF8000000, 0, 0, -1, -1, h);
    pulse_start();
    check_outs("illegal_start_ignored", '0, 1'b0);
    Clear = 1'b1;
    tick();
    Clear     = 1'b0;
    m_illegal = 1'b0;
    check_outs("illegal_cleared", '0, 1'b0);
`endif

    // Randomized instruction stream with random stalls and occasional Stop
    pulse_start();
    for (int k = 0; k < 80; k++) begin
      ir      = $urandom;
      stop_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : -1;
      run_instr("rand", ir, -1, -1, stop_at, -1, h);
      if (h) begin
        if (m_illegal) begin
          Clear = 1'b1;
          tick();
          Clear     = 1'b0;
          m_illegal = 1'b0;
        end
        pulse_start();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mini_src_control_unit.md
Name: mini_src_control_unit

Overview:
- Hardwired Mini-SRC control sequencer; sits directly upstream of the Datapath.
- Generates every bus-drive, register-load, ALU and memory strobe that the datapath benches currently drive by hand.
- Runs fetch (T0-T2) then opcode-specific execute steps (T3-T7), with Read/Write handshakes against memory.
- Loops until a halt instruction or a stop request.

Parameters:
- OPW, 5, opcode width (IR[31:27]).
- MEM_WAIT_MAX, 15, cycles a memory step may wait for MemReady before faulting.

Ports:
- Clock  in  1  system clock; everything updates on posedge.
- Clear  in  1  reset; synchronous, active-high.
- Start  in  1  one-cycle pulse; leaves IDLE/HALTED.
- Stop  in  1  one-cycle pulse; halt after the current instruction completes.
- IR  in  32  instruction register contents from the datapath.
- MemReady  in  1  memory completes the current Read/Write this cycle.
- bus_out  out  8  one-hot bus driver: [7]PCout [6]Zhighout [5]Zlowout [4]MDRout [3]HIout [2]LOout [1]Cout [0]Rout.
- reg_in  out  9  load enables: [8]PCin [7]MARin [6]MDRin [5]IRin [4]Yin [3]Zin [2]HIin [1]LOin [0]Rin.
- Gra, Grb, Grc  out  1 each  register-field select for select-and-encode.
- BAout  out  1  base-address R0-as-zero drive.
- IncPC  out  1  ALU PC+1 in T0.
- Read, Write  out  1 each  memory strobes; Read also selects Mdatain into MDR.
- ALU_op  out  5  ALU operation code.
- Running  out  1  high in any non-IDLE, non-HALTED state.
- Fault  out  1  sticky; set on memory timeout.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All strobes are 0; ALU_op = 0; Running = 0; Fault = 0; wait counter = 0.
  - Clear mid-instruction aborts at the next posedge; no partial strobe survives.
- All outputs are registered-state decodes (Moore); they change only on the posedge.
- bus_out is at most one-hot in every state.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, T7, HALTED.
- Start in IDLE/HALTED goes to T0. Start is ignored elsewhere and while Fault = 1.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin. Holds until MemReady.
  - T2: MDRout, IRin.
- Execute, by opcode IR[31:27]:
  - R-format ALU (add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000, ror 01001, rol 01010):
    - T3: Grb, Rout, Yin.
    - T4: Grc, Rout, ALU_op = opcode, Zin.
    - T5: Zlowout, Gra, Rin.
  - Immediate (addi 01011, andi 01100, ori 01101): as R-format, but T4 uses Cout instead of Grc/Rout.
  - ldi 00001: T3 Grb, BAout, Yin; T4 Cout, ALU_op = add, Zin; T5 Zlowout, Gra, Rin.
  - ld 00000:
    - T3-T4 as ldi.
    - T5: Zlowout, MARin.
    - T6: Read, MDRin; waits on MemReady.
    - T7: MDRout, Gra, Rin.
  - st 00010:
    - T3-T5 as ld.
    - T6: Gra, Rout, MDRin (Read = 0).
    - T7: Write; waits on MemReady.
  - mul 01110 / div 01111:
    - T3: Gra, Rout, Yin.
    - T4: Grb, Rout, ALU_op, Zin.
    - T5: Zlowout, LOin.
    - T6: Zhighout, HIin.
  - neg 10000 / not 10001: T3 Grb, Rout, ALU_op, Zin; T4 Zlowout, Gra, Rin.
  - nop 11010: back to T0 after T2.
  - halt 11011: T2 goes to HALTED.
- After the last execute step, go to T0, or to HALTED if a Stop latch is set. The Stop latch sets on a Stop pulse and clears on entering HALTED.
- Memory steps (T1, ld T6, st T7):
  - The strobe holds and the state is stalled while MemReady = 0.
  - The wait counter increments each stalled cycle and resets on leaving the step.
  - Counter reaching MEM_WAIT_MAX sets Fault, drops all strobes and goes to HALTED.
  - MemReady in the first cycle of the step means zero-stall advance.
- Unlisted opcodes are treated as nop (see optional feature).
- Stop and a memory stall in the same cycle: the stall resolves first, and Stop takes effect at the instruction end.

Optional Feature:
- Macro: MINI_SRC_ILLEGAL_TRAP_EN.
- Defined: an unlisted opcode in T2 goes to HALTED and sets a sticky Illegal output port (reset 0, cleared only by Clear). Start is ignored while Illegal = 1.
- Undefined: no Illegal port; unlisted opcodes behave as nop.

Decomposition:
- Package mini_src_pkg holds:
  - opcode localparams;
  - state enum encoding (4-bit);
  - bus_out and reg_in bit-index constants;
  - ALU_op add code.
- Sub-module mini_src_mem_wait: per-step wait counter plus timeout flag. Inputs: step_active, MemReady. Outputs: done, timeout.

Test Plan:
- Clear, Start, IR = 0x28918000 (and R1,R2,R3), MemReady tied 1 -> T0..T5 in 6 cycles. T4 has ALU_op = 00101, Grc, Rout, Zin. T5 has Zlowout, Gra, Rin. Then back to T0.
- ld with MemReady low 3 cycles in T6 -> Read and MDRin held 4 cycles, then T7 MDRout, Gra, Rin. Fault stays 0.
- MemReady held 0 in T1 -> Fault = 1 after MEM_WAIT_MAX = 15 stalled cycles, state HALTED, all strobes 0. A later Start is ignored.
- IR = halt (0xD8000000) -> HALTED after T2, Running = 0. Start -> T0.
- Clear asserted during T4 of mul -> next cycle IDLE with all outputs 0. HIin and LOin never asserted.
- Stop pulse during T3 of add -> instruction finishes T5, then HALTED; with MINI_SRC_ILLEGAL_TRAP_EN, IR opcode 11111 -> HALTED and Illegal = 1.
